// File: rtl/outbuf.sv
// ============================================================================
// Module   : outbuf
// Brief    : Two-entry output skid buffer (output + skid register) between the
//            core and the downstream consumer; odata/ovalid/cstop are flop
//            outputs. Optional statistics counters under OUTBUF_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NUM
`define NUM 15
`endif

module outbuf #(
  parameter int DW = `NUM + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] cdata,
  input  logic                 cvalid,
  output logic                 cstop,
  output logic signed [DW-1:0] odata,
  output logic                 ovalid,
  input  logic                 ostop,
  output logic [31:0]          nbeats,
  output logic [31:0]          nstalls
);

  // Encoding chosen so bit 0 is ovalid and bit 1 is cstop straight from the flops.
  localparam logic [1:0] c_EMPTY = 2'b00;
  localparam logic [1:0] c_ONE   = 2'b01;
  localparam logic [1:0] c_TWO   = 2'b11;

  logic [1:0]          r_state;
  logic signed [DW-1:0] r_oreg;
  logic signed [DW-1:0] r_sreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_EMPTY;
      r_oreg  <= '0;
      r_sreg  <= '0;
    end else begin
      case (r_state)
        c_EMPTY: begin
          if (cvalid) begin
            r_oreg  <= cdata;
            r_state <= c_ONE;
          end
        end
        c_ONE: begin
          if (cvalid && !ostop) begin
            r_oreg <= cdata;
          end else if (cvalid) begin
            r_sreg  <= cdata;
            r_state <= c_TWO;
          end else if (!ostop) begin
            r_state <= c_EMPTY;
          end
        end
        c_TWO: begin
          if (!ostop) begin
            r_oreg  <= r_sreg;
            r_state <= c_ONE;
          end
        end
        default: r_state <= c_EMPTY;
      endcase
    end
  end

  assign ovalid = r_state[0];
  assign cstop  = r_state[1];
  assign odata  = r_oreg;

`ifdef OUTBUF_STATS_EN
  logic [31:0] r_nbeats;
  logic [31:0] r_nstalls;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_nbeats  <= '0;
      r_nstalls <= '0;
    end else if (ovalid) begin
      if (ostop) r_nstalls <= r_nstalls + 32'd1;
      else       r_nbeats  <= r_nbeats + 32'd1;
    end
  end

  assign nbeats  = r_nbeats;
  assign nstalls = r_nstalls;
`else
  assign nbeats  = 32'd0;
  assign nstalls = 32'd0;
`endif

endmodule

`default_nettype wire
